tt_sweep_driver: RTL and testbench

Upstream stimulus-and-capture stage for a 3-input combinational logic gate. On a start request it drives all eight `{in1,in2,in3}` combinations into the gate and holds each one for a programmable settle window. It samples the gate's `out` for each combination and assembles the observed 8-bit truth table in the codebase's hex naming order, so a gate built as `0x68` reads back as 8'h68. It compares the captured table against an expected value and reports the result through a start/done handshake.

---
 rtl/tt_sweep_driver.sv | 149 ++++++++++++++
 tb/tb_tt_sweep_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_driver.sv
// tt_sweep_driver: drives all eight {in1,in2,in3} rows into a 3-input gate,
// samples its output after a settle window and checks the captured truth table.
//
// Build option: define TT_SWEEP_VOTE_EN to take three samples per row and
// store the 2-of-3 majority (each row then takes SETTLE_CYCLES + 3 cycles).
//
// Ports:
//   clk              clock, all state changes on the rising edge
//   rst              asynchronous active-high reset
//   start_i          sweep request, only looked at while idle
//   expected_i       expected truth table, latched when a sweep starts
//   dut_out_i        output of the gate being driven
//   in1_o/in2_o/in3_o registered gate inputs; in1_o is the MSB of the row
//   busy_o           high from start acceptance until done_o
//   done_o           one-cycle pulse when table/match/mask are valid
//   table_o          captured table; bit 7-r holds the sample for row r
//   match_o          table_o == latched expected, held until the next done
//   mismatch_mask_o  table_o ^ latched expected, same validity as match_o
module tt_sweep_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] expected_i,
    input  logic       dut_out_i,
    output logic       in1_o,
    output logic       in2_o,
    output logic       in3_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] table_o,
    output logic       match_o,
    output logic [7:0] mismatch_mask_o
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       row_q, row_d;
    logic [7:0]       exp_q, exp_d, table_q, table_d, mask_q, mask_d;
    logic             match_q, match_d, busy_q, busy_d, done_q, done_d;
    logic             last_sample, sample_bit;
`ifdef TT_SWEEP_VOTE_EN
    logic [1:0]       ph_q, ph_d, vote_q, vote_d;
    // the first two samples are parked in vote_q; the third edge resolves the majority
    assign last_sample = ph_q == 2'd2;
    assign sample_bit  = (vote_q[0] & vote_q[1]) | (dut_out_i & (vote_q[0] | vote_q[1]));
`else
    assign last_sample = 1'b1;
    assign sample_bit  = dut_out_i;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            mask_q  <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TT_SWEEP_VOTE_EN
            ph_q    <= '0;
            vote_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            mask_q  <= mask_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TT_SWEEP_VOTE_EN
            ph_q    <= ph_d;
            vote_q  <= vote_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        exp_d   = exp_q;
        table_d = table_q;
        mask_d  = mask_q;
        match_d = match_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef TT_SWEEP_VOTE_EN
        ph_d    = ph_q;
        vote_d  = vote_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SETTLE;
                    row_d   = '0;
                    exp_d   = expected_i;
                    table_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SETTLE: begin
                // counter saturates at SETTLE_CYCLES so it can never wrap CNT_W
                if (cnt_q < CNT_W'(SETTLE_CYCLES)) cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
            end
            SAMPLE: begin
`ifdef TT_SWEEP_VOTE_EN
                ph_d             = ph_q + 2'd1;
                vote_d[ph_q[0]]  = dut_out_i;
`endif
                if (last_sample) begin
                    table_d[3'd7 - row_q] = sample_bit;
`ifdef TT_SWEEP_VOTE_EN
                    ph_d = '0;
`endif
                    if (row_q == 3'd7) begin
                        state_d = FINISH;
                    end else begin
                        row_d   = row_q + 3'd1;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
            end
            FINISH: begin
                match_d = table_q == exp_q;
                mask_d  = table_q ^ exp_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign {in1_o, in2_o, in3_o} = row_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign table_o         = table_q;
    assign match_o         = match_q;
    assign mismatch_mask_o = mask_q;
endmodule

// File: tb/tb_tt_sweep_driver.sv
// tb_tt_sweep_driver: scoreboard bench for tt_sweep_driver against a gate model.
module tb_tt_sweep_driver;
    localparam int S = 4;
`ifdef TT_SWEEP_VOTE_EN
    localparam int P = S + 3;
`else
    localparam int P = S + 1;
`endif
    localparam int LAT = 8 * P + 1;

    logic       clk = 1'b0, rst = 1'b1, start_i = 1'b0, dut_out_i;
    logic [7:0] expected_i = 8'h00;
    logic       in1_o, in2_o, in3_o, busy_o, done_o, match_o;
    logic [7:0] table_o, mismatch_mask_o;
    logic [7:0] gate_code = 8'h68;
    logic       force_one = 1'b0, glitch = 1'b0;
    logic [2:0] row;

    typedef struct {
        logic [7:0] tbl;
        logic [7:0] exp;
        int         acc;
    } exp_t;
    exp_t sbq[$];
    exp_t e;
    int   total = 0, bad = 0, cyc = 0, k;

    tt_sweep_driver #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .expected_i(expected_i),
        .dut_out_i(dut_out_i), .in1_o(in1_o), .in2_o(in2_o), .in3_o(in3_o),
        .busy_o(busy_o), .done_o(done_o), .table_o(table_o), .match_o(match_o),
        .mismatch_mask_o(mismatch_mask_o)
    );

    assign row       = {in1_o, in2_o, in3_o};
    assign dut_out_i = (force_one | gate_code[3'd7 - row]) ^ glitch;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // truth table of the attached gate, built row by row from its output rule
    function automatic logic [7:0] ref_table(input logic [7:0] code, input logic one);
        logic [7:0] t;
        t = '0;
        for (int r = 0; r < 8; r++) t[7 - r] = one | code[7 - r];
        return t;
    endfunction

    // monitor: pops one entry per done pulse; between pulses checks row/busy timing
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) begin
                if (sbq.size() == 0) chk("spurious_done", done_o, 0);
                else begin
                    e = sbq.pop_front();
                    chk("table", table_o, e.tbl);
                    chk("match", match_o, e.tbl == e.exp);
                    chk("mask", mismatch_mask_o, e.tbl ^ e.exp);
                    chk("latency", cyc - e.acc, LAT);
                    chk("busy_at_done", busy_o, 0);
                end
            end else if (sbq.size() > 0 && cyc >= sbq[0].acc) begin
                k = cyc - sbq[0].acc;
                chk("row", row, (k / P > 7) ? 7 : k / P);
                chk("busy", busy_o, 1);
            end
        end
    end

    task automatic sweep(input logic [7:0] code, input logic [7:0] ex);
        gate_code  = code;
        expected_i = ex;
        start_i    = 1'b1;
        sbq.push_back('{ref_table(code, force_one), ex, cyc + 1});
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() > 0 && n < 4 * LAT + 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            chk("timeout_pending", sbq.size(), 0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_row(input logic [2:0] r);
        int n = 0;
        while (row != r && n < LAT) begin
            @(negedge clk);
            n++;
        end
        chk("wait_row", row, r);
    endtask

    task automatic glitch_at(input int m);
        repeat (m) @(negedge clk);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
    endtask

    initial begin
        logic [7:0] c, x;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_table", table_o, 0);
        chk("rst_match", match_o, 0);
        chk("rst_mask", mismatch_mask_o, 0);
        chk("rst_row", row, 0);
        rst = 1'b0;
        @(negedge clk);

        sweep(8'h68, 8'h68);
        wait_idle();
        chk("held_row7", row, 7);

        sweep(8'h68, 8'h69);
        wait_idle();
        chk("mask_69", mismatch_mask_o, 8'h01);

        force_one = 1'b1;
        sweep(8'h00, 8'hA5);
        wait_row(3'd3);
        start_i    = 1'b1;
        expected_i = 8'h5A;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle();
        force_one = 1'b0;
        chk("ignored_start_mask", mismatch_mask_o, 8'h5A);

        sweep(8'h68, 8'h68);
        wait_row(3'd5);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_table", table_o, 0);
        chk("arst_match", match_o, 0);
        chk("arst_mask", mismatch_mask_o, 0);
        chk("arst_row", row, 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sweep(8'h68, 8'h68);
        wait_idle();

        gate_code  = $urandom;
        expected_i = $urandom;
        for (int j = 0; j < 100; j++)
            if (j % (LAT + 1) == 0) sbq.push_back('{ref_table(gate_code, 1'b0), expected_i, cyc + 1 + j});
        start_i = 1'b1;
        repeat (100) @(negedge clk);
        start_i = 1'b0;
        wait_idle();

        sweep(8'h68, 8'h68);
        glitch_at(2 * P + S + 1);
        wait_idle();

        repeat (8) begin
            c = $urandom;
            x = ($urandom_range(0, 1) == 1) ? c : 8'($urandom);
            sweep(c, x);
`ifdef TT_SWEEP_VOTE_EN
            glitch_at($urandom_range(0, 7) * P + S + $urandom_range(1, 3) - 1);
`endif
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
